// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit packet arbiter: packet beat layout,
// arbiter state encoding and drop-counter width.
package uart_tx_arbiter_pkg;

    localparam int DROP_CNT_W = 8;
    localparam int LEN_W      = 8;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] Source;
        logic [ADDR_W-1:0] Destination;
        logic [LEN_W-1:0]  Length;
        logic              SoP;
        logic              EoP;
        logic [DATA_W-1:0] Data;
        logic              Valid;
    } UART_PACKET;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin search: first requester at or after last_grant+1 (mod N)
// whose request bit is set.
module rr_pick #(
    parameter int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic         hit,
    output logic [W-1:0] idx
);

    int cand;

    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(last_grant) + i) % N;
            if (!hit && req[W'(cand)]) begin
                hit = 1'b1;
                idx = W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter in front of the UART transmitter:
// forwards whole packets, drops misframed beats, flags length mismatches.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_SRC = 2,
    localparam int GW = $clog2(N_SRC)
) (
    input  logic                  ipClk,
    input  logic                  ipReset,
    input  UART_PACKET            ipTxPacket [N_SRC],
    output logic [N_SRC-1:0]      opTxReady,
    output UART_PACKET            opTxPacket,
    input  logic                  ipTxReady,
    output logic [GW-1:0]         opGrant,
    output logic                  opLengthError,
    output logic [DROP_CNT_W-1:0] opDropCount
);

    arb_state_t            state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [LEN_W-1:0]      len_q, len_d;
    UART_PACKET            out_q, out_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  lerr_q, lerr_d;

    logic [N_SRC-1:0]      sop_req;
    logic [N_SRC-1:0]      misframed;
    logic                  pick_hit;
    logic [GW-1:0]         pick_idx;
    logic [3:0]            n_drop;
    logic [DROP_CNT_W:0]   drop_sum;
    logic [LEN_W-1:0]      cnt_inc;
    UART_PACKET            gnt_pkt;
    logic                  accept;

    always_comb begin
        sop_req   = '0;
        misframed = '0;
        for (int i = 0; i < N_SRC; i++) begin
            sop_req[i]   = ipTxPacket[i].Valid && ipTxPacket[i].SoP;
            misframed[i] = ipTxPacket[i].Valid && !ipTxPacket[i].SoP;
        end
    end

    rr_pick #(
        .N (N_SRC)
    ) u_pick (
        .req        (sop_req),
        .last_grant (grant_q),
        .hit        (pick_hit),
        .idx        (pick_idx)
    );

    assign gnt_pkt = ipTxPacket[grant_q];
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        drop_d    = drop_q;
        lerr_d    = 1'b0;
        opTxReady = '0;
        accept    = 1'b0;
        n_drop    = '0;
        drop_sum  = '0;
        out_d     = out_q;
        // A completed transfer empties the output slot unless refilled below.
        if (ipTxReady) begin
            out_d.Valid = 1'b0;
        end

        if (!ipReset) begin
            unique case (state_q)
                IDLE: begin
                    opTxReady = misframed;
                    n_drop    = 4'($countones(misframed));
                    drop_sum  = {1'b0, drop_q} + (DROP_CNT_W + 1)'(n_drop);
                    drop_d    = drop_sum[DROP_CNT_W] ? '1
                                                     : drop_sum[DROP_CNT_W-1:0];
                    if (pick_hit) begin
                        grant_d = pick_idx;
                        cnt_d   = '0;
                        len_d   = ipTxPacket[pick_idx].Length;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    opTxReady[grant_q] = !out_q.Valid || ipTxReady;
                    accept = gnt_pkt.Valid && (!out_q.Valid || ipTxReady);
                    if (accept) begin
                        out_d       = gnt_pkt;
                        out_d.Valid = 1'b1;
                        cnt_d       = cnt_inc;
                        if (gnt_pkt.EoP) begin
                            state_d = IDLE;
                            lerr_d  = (len_q == '0) || (cnt_inc != len_q);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state_q <= IDLE;
            grant_q <= GW'(N_SRC - 1);
            cnt_q   <= '0;
            len_q   <= '0;
            out_q   <= '0;
            drop_q  <= '0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            lerr_q  <= lerr_d;
        end
    end

    assign opTxPacket    = out_q;
    assign opGrant       = grant_q;
    assign opLengthError = lerr_q;
    assign opDropCount   = drop_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle table plus packet-level
// sequences for arbitration, backpressure, reset and drop saturation.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txr = 1'b1;
    UART_PACKET pin [2];
    logic [1:0] rdy;
    UART_PACKET pout;
    logic       gnt;
    logic       lerr;
    logic [7:0] dropc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_SRC(2)) dut (
        .ipClk         (clk),
        .ipReset       (rst),
        .ipTxPacket    (pin),
        .opTxReady     (rdy),
        .opTxPacket    (pout),
        .ipTxReady     (txr),
        .opGrant       (gnt),
        .opLengthError (lerr),
        .opDropCount   (dropc)
    );

    typedef struct {
        logic [1:0] v, sop, eop;
        logic [7:0] d0, d1, len0;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] erdy;
        logic       eg, el;
        logic [7:0] edr;
    } vec_t;

    vec_t       tbl [22];
    UART_PACKET sbeat [2][16];
    int         scount [2];
    int         spos [2];
    UART_PACKET expq [32];
    int         nexp;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic UART_PACKET beat(input int src, input logic v,
        input logic sop, input logic eop, input logic [7:0] d,
        input logic [7:0] len);
        UART_PACKET p;
        p = '0;
        p.Source = 8'(src);
        p.Length = len;
        p.SoP = sop;
        p.EoP = eop;
        p.Data = d;
        p.Valid = v;
        return p;
    endfunction

    function automatic vec_t mk(input logic [1:0] v, sop, eop,
        input logic [7:0] d0, d1, len0, input logic ev,
        input logic [7:0] ed, input logic [1:0] erdy,
        input logic eg, el, input logic [7:0] edr);
        vec_t t;
        t.v = v; t.sop = sop; t.eop = eop;
        t.d0 = d0; t.d1 = d1; t.len0 = len0;
        t.ev = ev; t.ed = ed; t.erdy = erdy;
        t.eg = eg; t.el = el; t.edr = edr;
        return t;
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        txr = 1'b1;
        pin[0] = '0;
        pin[1] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Requesters present their head beat and advance only when accepted.
    task automatic run_auto(input int ncyc, input int lo_s, input int lo_e);
        UART_PACKET prev;
        int         got;
        logic       gap_due;
        logic       lerr_seen;
        logic [1:0] acc;
        got = 0;
        gap_due = 1'b0;
        lerr_seen = 1'b0;
        prev = '0;
        for (int c = 0; c < ncyc; c++) begin
            txr = !(c >= lo_s && c < lo_e);
            for (int i = 0; i < 2; i++)
                pin[i] = (spos[i] < scount[i]) ? sbeat[i][spos[i]] : '0;
            @(negedge clk);
            if (!txr && pout.Valid) begin
                check("bp_ready", 32'(rdy[gnt]), 0);
                if (c > lo_s) check("hold", 32'(pout !== prev), 0);
            end
            if (gap_due) begin
                check("gap", 32'(pout.Valid), 0);
                gap_due = 1'b0;
            end
            if (pout.Valid && txr) begin
                if (got < nexp) begin
                    check("beat_data", 32'(pout.Data), 32'(expq[got].Data));
                    check("beat_src", 32'(pout.Source), 32'(expq[got].Source));
                    check("beat_grant", 32'(gnt), 32'(expq[got].Source));
                end else begin
                    check("extra_beat", 32'(got), 32'(nexp - 1));
                end
                got++;
                if (pout.EoP) gap_due = 1'b1;
            end
            if (lerr) lerr_seen = 1'b1;
            for (int i = 0; i < 2; i++) acc[i] = pin[i].Valid && rdy[i];
            prev = pout;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) if (acc[i]) spos[i]++;
        end
        check("beat_count", 32'(got), 32'(nexp));
        check("auto_lerr", 32'(lerr_seen), 0);
        txr = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        //          v      sop    eop    d0     d1     len ev ed     erdy  g  l dr
        tbl[0]  = mk(2'b01,2'b01,2'b00,8'h55,8'h00,8'd3,0,8'h00,2'b00,1,0,8'd0);
        tbl[1]  = mk(2'b01,2'b01,2'b00,8'h55,8'h00,8'd3,0,8'h00,2'b01,0,0,8'd0);
        tbl[2]  = mk(2'b01,2'b00,2'b00,8'hA1,8'h00,8'd3,1,8'h55,2'b01,0,0,8'd0);
        tbl[3]  = mk(2'b01,2'b00,2'b01,8'h7E,8'h00,8'd3,1,8'hA1,2'b01,0,0,8'd0);
        tbl[4]  = mk(2'b00,2'b00,2'b00,8'h00,8'h00,8'd0,1,8'h7E,2'b00,0,0,8'd0);
        tbl[5]  = mk(2'b00,2'b00,2'b00,8'h00,8'h00,8'd0,0,8'h00,2'b00,0,0,8'd0);
        tbl[6]  = mk(2'b01,2'b01,2'b00,8'h11,8'h00,8'd4,0,8'h00,2'b00,0,0,8'd0);
        tbl[7]  = mk(2'b01,2'b01,2'b00,8'h11,8'h00,8'd4,0,8'h00,2'b01,0,0,8'd0);
        tbl[8]  = mk(2'b01,2'b00,2'b00,8'h22,8'h00,8'd4,1,8'h11,2'b01,0,0,8'd0);
        tbl[9]  = mk(2'b01,2'b00,2'b01,8'h33,8'h00,8'd4,1,8'h22,2'b01,0,0,8'd0);
        tbl[10] = mk(2'b00,2'b00,2'b00,8'h00,8'h00,8'd0,1,8'h33,2'b00,0,1,8'd0);
        tbl[11] = mk(2'b00,2'b00,2'b00,8'h00,8'h00,8'd0,0,8'h00,2'b00,0,0,8'd0);
        tbl[12] = mk(2'b10,2'b00,2'b00,8'h00,8'hD1,8'd0,0,8'h00,2'b10,0,0,8'd0);
        tbl[13] = mk(2'b10,2'b00,2'b00,8'h00,8'hD2,8'd0,0,8'h00,2'b10,0,0,8'd1);
        tbl[14] = mk(2'b10,2'b00,2'b00,8'h00,8'hD3,8'd0,0,8'h00,2'b10,0,0,8'd2);
        tbl[15] = mk(2'b00,2'b00,2'b00,8'h00,8'h00,8'd0,0,8'h00,2'b00,0,0,8'd3);
        tbl[16] = mk(2'b11,2'b01,2'b00,8'h44,8'hD4,8'd1,0,8'h00,2'b10,0,0,8'd3);
        tbl[17] = mk(2'b01,2'b01,2'b01,8'h44,8'h00,8'd1,0,8'h00,2'b01,0,0,8'd4);
        tbl[18] = mk(2'b00,2'b00,2'b00,8'h00,8'h00,8'd0,1,8'h44,2'b00,0,0,8'd4);
        tbl[19] = mk(2'b00,2'b00,2'b00,8'h00,8'h00,8'd0,0,8'h00,2'b00,0,0,8'd4);
        tbl[20] = mk(2'b11,2'b00,2'b00,8'hE0,8'hE1,8'd0,0,8'h00,2'b11,0,0,8'd4);
        tbl[21] = mk(2'b00,2'b00,2'b00,8'h00,8'h00,8'd0,0,8'h00,2'b00,0,0,8'd6);

        // Reset values, including ready held low while reset is asserted.
        rst = 1'b1;
        pin[0] = '0;
        pin[1] = beat(1, 1, 0, 0, 8'hBB, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready_in_reset", 32'(rdy), 0);
        pin[1] = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(pout.Valid), 0);
        check("rst_data", 32'(pout.Data), 0);
        check("rst_grant", 32'(gnt), 1);
        check("rst_drop", 32'(dropc), 0);
        check("rst_lerr", 32'(lerr), 0);
        check("rst_ready", 32'(rdy), 0);
        @(posedge clk);
        #1;

        for (int k = 0; k < 22; k++) begin
            pin[0] = beat(0, tbl[k].v[0], tbl[k].sop[0], tbl[k].eop[0],
                          tbl[k].d0, tbl[k].len0);
            pin[1] = beat(1, tbl[k].v[1], tbl[k].sop[1], tbl[k].eop[1],
                          tbl[k].d1, 8'd0);
            @(negedge clk);
            check($sformatf("v%0d_valid", k), 32'(pout.Valid), 32'(tbl[k].ev));
            if (tbl[k].ev)
                check($sformatf("v%0d_data", k), 32'(pout.Data), 32'(tbl[k].ed));
            check($sformatf("v%0d_ready", k), 32'(rdy), 32'(tbl[k].erdy));
            check($sformatf("v%0d_grant", k), 32'(gnt), 32'(tbl[k].eg));
            check($sformatf("v%0d_lerr", k), 32'(lerr), 32'(tbl[k].el));
            check($sformatf("v%0d_drop", k), 32'(dropc), 32'(tbl[k].edr));
            @(posedge clk);
            #1;
        end

        // Both requesters hold two 3-beat packets: grants must alternate.
        reset_dut();
        nexp = 0;
        for (int s = 0; s < 2; s++) begin
            spos[s] = 0;
            scount[s] = 6;
        end
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 2; s++)
                for (int b = 0; b < 3; b++) begin
                    sbeat[s][p*3+b] = beat(s, 1, b == 0, b == 2,
                                           8'(s*16 + p*4 + b), 8'd3);
                    expq[nexp] = sbeat[s][p*3+b];
                    nexp++;
                end
        run_auto(30, 100, 100);

        // One 6-beat packet with ipTxReady low for 5 cycles mid-packet.
        reset_dut();
        nexp = 0;
        spos[0] = 0;
        spos[1] = 0;
        scount[0] = 6;
        scount[1] = 0;
        for (int b = 0; b < 6; b++) begin
            sbeat[0][b] = beat(0, 1, b == 0, b == 5, 8'(8'hC0 + b), 8'd6);
            expq[nexp] = sbeat[0][b];
            nexp++;
        end
        run_auto(20, 4, 9);

        // Reset while the second beat of a 4-beat packet is presented.
        reset_dut();
        pin[0] = beat(0, 1, 1, 0, 8'h60, 8'd4);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_accept_sop", 32'(rdy), 32'(2'b01));
        @(posedge clk);
        #1;
        pin[0] = beat(0, 1, 0, 0, 8'h61, 8'd4);
        rst = 1'b1;
        @(negedge clk);
        check("mid_first_out", 32'(pout.Data), 32'h60);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pin[0] = '0;
        @(negedge clk);
        check("mid_valid", 32'(pout.Valid), 0);
        check("mid_grant", 32'(gnt), 1);
        check("mid_drop", 32'(dropc), 0);
        check("mid_lerr", 32'(lerr), 0);
        check("mid_ready", 32'(rdy), 0);
        begin
            int seen;
            seen = 0;
            repeat (3) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                if (pout.Valid) seen++;
            end
            check("mid_no_tail", 32'(seen), 0);
        end
        @(posedge clk);
        #1;
        pin[1] = beat(1, 1, 1, 1, 8'h70, 8'd1);
        @(negedge clk);
        check("mid_idle_decide", 32'(rdy), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_new_accept", 32'(rdy), 32'(2'b10));
        check("mid_new_grant", 32'(gnt), 1);
        @(posedge clk);
        #1;
        pin[1] = '0;
        @(negedge clk);
        check("mid_new_out", 32'(pout.Data), 32'h70);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_new_lerr", 32'(lerr), 0);

        // 300 misframed beats saturate the drop counter.
        reset_dut();
        pin[1] = beat(1, 1, 0, 0, 8'hEE, 8'd0);
        repeat (300) @(posedge clk);
        #1;
        pin[1] = '0;
        @(negedge clk);
        check("drop_saturate", 32'(dropc), 255);
        check("drop_no_output", 32'(pout.Valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-atomic round-robin arbiter that shares the single UART transmit packet stream between several packet sources, e.g. the register control block's read responses and a streaming source. It sits between the requesters and the UART transmitter. It forwards whole packets (SoP through EoP) without interleaving, drops misframed beats, and flags packets whose beat count disagrees with their Length field.

## Interface

Parameters:
- N_SRC, default 2: number of requesters, 2..8.

Ports:
- ipClk, in, 1: system clock. One clock domain; reset is synchronous and active-high.
- ipReset, in, 1: synchronous active-high reset, sampled on ipClk.
- ipTxPacket[N_SRC], in, UART_PACKET: requester streams (Source, Destination, Length, SoP, EoP, Data, Valid).
- opTxReady[N_SRC], out, 1 each: beat of requester i accepted this cycle when ipTxPacket[i].Valid && opTxReady[i].
- opTxPacket, out, UART_PACKET: registered output stream to the UART transmitter.
- ipTxReady, in, 1: transmitter accepts opTxPacket when opTxPacket.Valid && ipTxReady.
- opGrant, out, $clog2(N_SRC): index of the current or last granted requester.
- opLengthError, out, 1: one-cycle pulse on the cycle after an EoP beat whose packet beat count != Length.
- opDropCount, out, 8: saturating count of dropped misframed beats.

## Operation

- States: IDLE, BUSY.
- IDLE:
  - Scan requesters starting at (opGrant+1) mod N_SRC for the first one with Valid && SoP.
  - On a hit: opGrant <= that index, beat counter <= 0, go to BUSY.
  - No beat is accepted in the decision cycle.
- IDLE, misframed beats: any requester presenting Valid && !SoP gets opTxReady=1 for that cycle, so the beat is consumed and discarded. opDropCount increments by the number of beats dropped that cycle and saturates at 255.
- BUSY:
  - opTxReady[opGrant] = !opTxPacket.Valid || ipTxReady. All other opTxReady are 0.
  - Each accepted beat is copied into opTxPacket with Valid=1 and increments the 8-bit beat counter.
  - The accepted EoP beat returns the state to IDLE.
  - An SoP seen mid-packet is forwarded unchanged; the arbiter does not police it.
- Length check:
  - On the accepted EoP beat, compare counter+1 (8-bit wrap) against the Length field latched from the SoP beat.
  - A mismatch pulses opLengthError.
  - Length 0 always mismatches.
- Output register:
  - Holds its value while opTxPacket.Valid && !ipTxReady.
  - Clears Valid after a transfer unless a new beat is accepted in the same cycle.
- Reset values:
  - opTxPacket: all fields 0, Valid 0.
  - opTxReady: all 0.
  - opGrant = N_SRC-1, so requester 0 has first priority.
  - opDropCount = 0, opLengthError = 0, state IDLE.
- Reset mid-packet: abandon immediately. Output Valid is 0 on the next cycle, and the truncated packet is not completed. Requesters must also be reset.

## Timing

- Latency: an accepted input beat appears on opTxPacket on the next cycle.
- Throughput: 1 beat/cycle while ipTxReady is high.
- Packet gap: at least 1 cycle between packets, from the EoP-accept cycle through the IDLE decision cycle.
  - Example: EoP accepted in cycle t, state is IDLE in t+1, next SoP accepted no earlier than t+2.
- Backpressure: with ipTxReady low and the output full, opTxReady[opGrant] is 0 in the same cycle. The path is combinational from ipTxReady to opTxReady and must not be registered. No beat is lost or duplicated.
- Simultaneous events:
  - Output transfer and new beat accept in the same cycle: the output is overwritten and Valid stays 1.
  - Drop and grant decision in the same cycle for different requesters: both happen.
  - The granting requester itself is never dropped.
- opLengthError and opDropCount are updated one cycle after the EoP-accept or drop cycle.

## Structure

- A shared package holds:
  - the UART_PACKET struct;
  - the arbiter state enum (IDLE, BUSY);
  - the drop-counter width constant.
- The round-robin search goes in one combinational sub-module, rr_pick, with inputs request vector and last grant and outputs hit and index.
- All other logic stays in uart_tx_arbiter.

## Test plan

- Reset, then requester 0 sends packet {SoP,55},{A1},{EoP,7E} with Length=3 and ipTxReady=1 → output beats 55,A1,7E on consecutive cycles starting 2 cycles after the SoP is presented; opLengthError stays 0.
- Both requesters hold 3-beat packets continuously → grants alternate 0,1,0,1; no beat interleaving; ≥1 idle output cycle between packets.
- ipTxReady low for 5 cycles mid-packet → opTxPacket is held stable; the granted opTxReady is 0; all beats are delivered exactly once and in order.
- Requester 1 presents 3 beats without SoP while IDLE → all 3 consumed, nothing output, opDropCount=3. 300 such beats → opDropCount=255.
- A packet with Length=4 but EoP on beat 3 → packet is forwarded intact and opLengthError pulses for exactly 1 cycle.
- Assert ipReset during the 2nd beat of a 4-beat packet → output Valid is 0 the next cycle; opGrant=N_SRC-1, counters 0, state IDLE.
